mem_arbiter: RTL and testbench

//   Shares the single data-memory port between the processor core's load/store path (CORE)
//   and the program loader (PRG), which writes memory over UART during programming.
//   One transaction is in flight at a time. Grants are round-robin.

---
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core load/store path
// and the program loader, with a per-transaction timeout that aborts hung accesses.
module mem_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,

    input  logic        prg_req_i,
    input  logic        prg_we_i,
    input  logic [2:0]  prg_size_i,
    input  logic [31:0] prg_addr_i,
    input  logic [31:0] prg_wd_i,
    output logic [31:0] prg_rd_o,
    output logic        prg_ack_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [2:0]  mem_size_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i,

    output logic        err_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    // Requester identity: 0 = CORE, 1 = PRG.
    localparam logic SRC_CORE = 1'b0;
    localparam logic SRC_PRG  = 1'b1;

    state_t        r_state;
    state_t        w_stateNext;
    logic          r_lastGrant;
    logic          w_lastGrantNext;
    logic          r_owner;
    logic          w_ownerNext;
    logic          r_abandoned;
    logic          w_abandonedNext;
    logic [TW-1:0] r_tcnt;
    logic [TW-1:0] w_tcntNext;

    logic          r_memWe;
    logic          w_memWeNext;
    logic [2:0]    r_memSize;
    logic [2:0]    w_memSizeNext;
    logic [31:0]   r_memAddr;
    logic [31:0]   w_memAddrNext;
    logic [31:0]   r_memWd;
    logic [31:0]   w_memWdNext;

    logic          w_busy;
    logic          w_ownerReq;
    logic          w_timeoutHit;
    logic          w_done;
    logic          w_timeout;
    logic          w_complete;
    logic          w_coreComplete;
    logic          w_prgComplete;
    logic          w_grantPrg;
    logic [31:0]   w_rdData;

    assign w_busy       = (r_state == BUSY);
    assign w_ownerReq   = (r_owner == SRC_PRG) ? prg_req_i : core_req_i;
    assign w_timeoutHit = (r_tcnt == TW'(TIMEOUT - 1));
    assign w_done       = w_busy & (mem_ready_i | w_timeoutHit);

    // A ready arriving in the last allowed cycle counts as success, not a timeout.
    assign w_timeout      = w_busy & w_timeoutHit & ~mem_ready_i & ~rst_i;
    assign w_complete     = w_done & ~r_abandoned & w_ownerReq & ~rst_i;
    assign w_coreComplete = w_complete & (r_owner == SRC_CORE);
    assign w_prgComplete  = w_complete & (r_owner == SRC_PRG);
    assign w_rdData       = w_timeout ? 32'h0 : mem_rd_i;

    // On a tie the requester that did not win last time gets the port.
    assign w_grantPrg = (core_req_i & prg_req_i) ? ~r_lastGrant : prg_req_i;

    assign core_stall_o = core_req_i & ~w_coreComplete;
    assign core_rd_o    = w_coreComplete ? w_rdData : 32'h0;
    assign prg_ack_o    = w_prgComplete;
    assign prg_rd_o     = w_prgComplete ? w_rdData : 32'h0;
    assign err_o        = w_timeout;

    assign mem_req_o  = w_busy;
    assign mem_we_o   = r_memWe;
    assign mem_size_o = r_memSize;
    assign mem_addr_o = r_memAddr;
    assign mem_wd_o   = r_memWd;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_lastGrant <= SRC_PRG;
            r_owner     <= SRC_CORE;
            r_abandoned <= 1'b0;
            r_tcnt      <= '0;
            r_memWe     <= 1'b0;
            r_memSize   <= 3'b000;
            r_memAddr   <= 32'h0;
            r_memWd     <= 32'h0;
        end else begin
            r_state     <= w_stateNext;
            r_lastGrant <= w_lastGrantNext;
            r_owner     <= w_ownerNext;
            r_abandoned <= w_abandonedNext;
            r_tcnt      <= w_tcntNext;
            r_memWe     <= w_memWeNext;
            r_memSize   <= w_memSizeNext;
            r_memAddr   <= w_memAddrNext;
            r_memWd     <= w_memWdNext;
        end
    end

    always_comb begin
        w_stateNext     = r_state;
        w_lastGrantNext = r_lastGrant;
        w_ownerNext     = r_owner;
        w_abandonedNext = r_abandoned;
        w_tcntNext      = r_tcnt;
        w_memWeNext     = r_memWe;
        w_memSizeNext   = r_memSize;
        w_memAddrNext   = r_memAddr;
        w_memWdNext     = r_memWd;

        case (r_state)
            IDLE: begin
                if (core_req_i | prg_req_i) begin
                    w_stateNext     = BUSY;
                    w_ownerNext     = w_grantPrg;
                    w_lastGrantNext = w_grantPrg;
                    w_tcntNext      = '0;
                    w_abandonedNext = 1'b0;
                    if (w_grantPrg) begin
                        w_memWeNext   = prg_we_i;
                        w_memSizeNext = prg_size_i;
                        w_memAddrNext = prg_addr_i;
                        w_memWdNext   = prg_wd_i;
                    end else begin
                        w_memWeNext   = core_we_i;
                        w_memSizeNext = core_size_i;
                        w_memAddrNext = core_addr_i;
                        w_memWdNext   = core_wd_i;
                    end
                end
            end
            BUSY: begin
                // A dropped request (trap/mret) still lets memory finish, but nobody is told.
                if (!w_ownerReq) begin
                    w_abandonedNext = 1'b1;
                end
                if (w_done) begin
                    w_stateNext = IDLE;
                end else begin
                    w_tcntNext = r_tcnt + TW'(1);
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter: a transaction-level model of the
// arbitration rules predicts every output each cycle.
module tb_mem_arbiter;

    localparam int TIMEOUT = 16;
    localparam int NUM_CYCLES = 4000;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        core_req_i, core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i, core_wd_i, core_rd_o;
    logic        core_stall_o;
    logic        prg_req_i, prg_we_i;
    logic [2:0]  prg_size_i;
    logic [31:0] prg_addr_i, prg_wd_i, prg_rd_o;
    logic        prg_ack_o;
    logic        mem_req_o, mem_we_o;
    logic [2:0]  mem_size_o;
    logic [31:0] mem_addr_o, mem_wd_o, mem_rd_i;
    logic        mem_ready_i;
    logic        err_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
        .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
        .core_stall_o(core_stall_o),
        .prg_req_i(prg_req_i), .prg_we_i(prg_we_i), .prg_size_i(prg_size_i),
        .prg_addr_i(prg_addr_i), .prg_wd_i(prg_wd_i), .prg_rd_o(prg_rd_o),
        .prg_ack_o(prg_ack_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_size_o(mem_size_o),
        .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i),
        .mem_ready_i(mem_ready_i), .err_o(err_o)
    );

    // Model of the arbiter: one transaction record plus the round-robin memory.
    bit          mBusy;
    int          mOwner;
    int          mLastGrant;
    int          mAge;
    bit          mAbandoned;
    int          mLatency;
    logic        mWe;
    logic [2:0]  mSize;
    logic [31:0] mAddr, mWd;

    // Inputs to be applied just after the next rising edge.
    logic        nRst, nCoreReq, nCoreWe, nPrgReq, nPrgWe, nReady;
    logic [2:0]  nCoreSize, nPrgSize;
    logic [31:0] nCoreAddr, nCoreWd, nPrgAddr, nPrgWd;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus();
        rst_i       = nRst;
        core_req_i  = nCoreReq;
        core_we_i   = nCoreWe;
        core_size_i = nCoreSize;
        core_addr_i = nCoreAddr;
        core_wd_i   = nCoreWd;
        prg_req_i   = nPrgReq;
        prg_we_i    = nPrgWe;
        prg_size_i  = nPrgSize;
        prg_addr_i  = nPrgAddr;
        prg_wd_i    = nPrgWd;
        mem_ready_i = nReady;
        mem_rd_i    = $urandom;
    endtask

    // Called mid-cycle: predicts outputs, compares, then advances model and agents.
    task automatic stepModel();
        bit done, timedOut, comp, ownerReq, coreComp, prgComp;
        logic [31:0] rdv;
        int r;
        done = 0; timedOut = 0; comp = 0; ownerReq = 0;
        if (mBusy && !rst_i) begin
            ownerReq = (mOwner == 0) ? core_req_i : prg_req_i;
            timedOut = !mem_ready_i && (mAge == TIMEOUT);
            done     = mem_ready_i || (mAge == TIMEOUT);
            comp     = done && !mAbandoned && ownerReq;
        end
        coreComp = comp && (mOwner == 0);
        prgComp  = comp && (mOwner == 1);
        rdv = timedOut ? 32'h0 : mem_rd_i;

        checkOutput("mem_req", {31'b0, mem_req_o}, {31'b0, mBusy});
        if (mBusy) begin
            checkOutput("mem_we",   {31'b0, mem_we_o}, {31'b0, mWe});
            checkOutput("mem_size", {29'b0, mem_size_o}, {29'b0, mSize});
            checkOutput("mem_addr", mem_addr_o, mAddr);
            checkOutput("mem_wd",   mem_wd_o, mWd);
        end
        checkOutput("core_stall", {31'b0, core_stall_o}, {31'b0, core_req_i && !coreComp});
        checkOutput("core_rd",  core_rd_o, coreComp ? rdv : 32'h0);
        checkOutput("prg_ack",  {31'b0, prg_ack_o}, {31'b0, prgComp});
        checkOutput("prg_rd",   prg_rd_o, prgComp ? rdv : 32'h0);
        checkOutput("err",      {31'b0, err_o}, {31'b0, timedOut});

        if (rst_i) begin
            mBusy = 0;
            mLastGrant = 1;
        end else if (mBusy) begin
            if (!ownerReq) mAbandoned = 1;
            if (done) mBusy = 0;
            else mAge++;
        end else if (core_req_i || prg_req_i) begin
            if (core_req_i && prg_req_i) mOwner = (mLastGrant == 1) ? 0 : 1;
            else mOwner = core_req_i ? 0 : 1;
            mLastGrant = mOwner;
            mBusy = 1;
            mAge = 1;
            mAbandoned = 0;
            if (mOwner == 0) begin
                mWe = core_we_i; mSize = core_size_i; mAddr = core_addr_i; mWd = core_wd_i;
            end else begin
                mWe = prg_we_i; mSize = prg_size_i; mAddr = prg_addr_i; mWd = prg_wd_i;
            end
            r = $urandom_range(0, 9);
            if (r == 0) mLatency = 1000;
            else if (r == 1) mLatency = TIMEOUT;
            else mLatency = $urandom_range(1, 5);
        end

        if (core_req_i && coreComp) nCoreReq = 1'b0;
        else if (core_req_i) nCoreReq = ($urandom_range(0, 29) != 0);
        else if ($urandom_range(0, 1) == 1) begin
            nCoreReq  = 1'b1;
            nCoreWe   = 1'($urandom);
            nCoreSize = 3'($urandom);
            nCoreAddr = $urandom;
            nCoreWd   = $urandom;
        end

        if (prg_req_i && prgComp) nPrgReq = 1'b0;
        else if (!prg_req_i && $urandom_range(0, 2) == 0) begin
            nPrgReq  = 1'b1;
            nPrgWe   = 1'($urandom);
            nPrgSize = 3'($urandom);
            nPrgAddr = $urandom;
            nPrgWd   = $urandom;
        end

        nRst   = ($urandom_range(0, 199) == 0);
        nReady = mBusy ? (mAge >= mLatency) : 1'($urandom);
    endtask

    initial begin
        nRst = 1'b1; nCoreReq = 1'b1; nCoreWe = 1'b0; nCoreSize = 3'd2;
        nCoreAddr = 32'h100; nCoreWd = 32'h0;
        nPrgReq = 1'b0; nPrgWe = 1'b0; nPrgSize = 3'd0; nPrgAddr = 32'h0; nPrgWd = 32'h0;
        nReady = 1'b0;
        mBusy = 0; mOwner = 0; mLastGrant = 1; mAge = 0; mAbandoned = 0; mLatency = 1;
        mWe = 1'b0; mSize = 3'd0; mAddr = 32'h0; mWd = 32'h0;
        applyStimulus();

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_mem_req",  {31'b0, mem_req_o}, 32'h0);
        checkOutput("reset_mem_we",   {31'b0, mem_we_o}, 32'h0);
        checkOutput("reset_mem_size", {29'b0, mem_size_o}, 32'h0);
        checkOutput("reset_mem_addr", mem_addr_o, 32'h0);
        checkOutput("reset_mem_wd",   mem_wd_o, 32'h0);
        checkOutput("reset_stall",    {31'b0, core_stall_o}, 32'h1);
        checkOutput("reset_ack",      {31'b0, prg_ack_o}, 32'h0);
        checkOutput("reset_err",      {31'b0, err_o}, 32'h0);

        // First cycle out of reset: both sides request together, CORE must win.
        nRst = 1'b0;
        nPrgReq = 1'b1; nPrgWe = 1'b1; nPrgAddr = 32'h0; nPrgWd = 32'h13; nPrgSize = 3'd2;
        mBusy = 0; mLastGrant = 1;

        for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
            @(posedge clk);
            #1;
            applyStimulus();
            @(negedge clk);
            stepModel();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
